// File: rtl/conv2d_unroll9.sv
// Fully parallel 3x3 convolution: nine concurrent multipliers feeding a
// balanced adder tree, with the result registered one edge after start.
module conv2d_unroll9 #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    input  logic [DATA_W-1:0] in5,
    input  logic [DATA_W-1:0] in6,
    input  logic [DATA_W-1:0] in7,
    input  logic [DATA_W-1:0] in8,
    input  logic [DATA_W-1:0] k0,
    input  logic [DATA_W-1:0] k1,
    input  logic [DATA_W-1:0] k2,
    input  logic [DATA_W-1:0] k3,
    input  logic [DATA_W-1:0] k4,
    input  logic [DATA_W-1:0] k5,
    input  logic [DATA_W-1:0] k6,
    input  logic [DATA_W-1:0] k7,
    input  logic [DATA_W-1:0] k8,
    output logic [OUT_W-1:0]  out,
    output logic              done
);

    // Handshake: start is a valid with no ready (always accepted); done is a
    // one-cycle valid that qualifies out after the edge that sampled start.

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = 2 * DATA_W + 4;
    localparam int EXT_W  = (OUT_W > SUM_W) ? OUT_W : SUM_W;

    logic [DATA_W-1:0] px [9];
    logic [DATA_W-1:0] kx [9];
    logic [PROD_W-1:0] prod [9];

    assign px[0] = in0;
    assign px[1] = in1;
    assign px[2] = in2;
    assign px[3] = in3;
    assign px[4] = in4;
    assign px[5] = in5;
    assign px[6] = in6;
    assign px[7] = in7;
    assign px[8] = in8;

    assign kx[0] = k0;
    assign kx[1] = k1;
    assign kx[2] = k2;
    assign kx[3] = k3;
    assign kx[4] = k4;
    assign kx[5] = k5;
    assign kx[6] = k6;
    assign kx[7] = k7;
    assign kx[8] = k8;

    for (genvar i = 0; i < 9; i++) begin : g_mul
        assign prod[i] = px[i] * kx[i];
    end

    // Tree carries the full 20-bit width so no partial sum can overflow.
    logic [SUM_W-1:0] lvl1 [4];
    logic [SUM_W-1:0] lvl2 [2];
    logic [SUM_W-1:0] lvl3;
    logic [SUM_W-1:0] sum;
    logic [EXT_W-1:0] sum_ext;

    for (genvar j = 0; j < 4; j++) begin : g_lvl1
        assign lvl1[j] = SUM_W'(prod[2*j]) + SUM_W'(prod[2*j+1]);
    end

    assign lvl2[0] = lvl1[0] + lvl1[1];
    assign lvl2[1] = lvl1[2] + lvl1[3];
    assign lvl3    = lvl2[0] + lvl2[1];
    assign sum     = lvl3 + SUM_W'(prod[8]);
    assign sum_ext = EXT_W'(sum);

    // Result wraps modulo 2^OUT_W; out holds while start is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out  <= '0;
            done <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                out <= sum_ext[OUT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_conv2d_unroll9.sv
// Self-checking bench for conv2d_unroll9: directed scenarios plus random
// vectors, with a scoreboard of expected results popped whenever done fires.
module tb_conv2d_unroll9;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  win [9];
    logic [7:0]  kin [9];
    logic [15:0] out;
    logic        done;

    logic [15:0] exp_q [$];
    int          n_vec;
    int          n_err;

    conv2d_unroll9 #(.DATA_W(8), .OUT_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in0   (win[0]),
        .in1   (win[1]),
        .in2   (win[2]),
        .in3   (win[3]),
        .in4   (win[4]),
        .in5   (win[5]),
        .in6   (win[6]),
        .in7   (win[7]),
        .in8   (win[8]),
        .k0    (kin[0]),
        .k1    (kin[1]),
        .k2    (kin[2]),
        .k3    (kin[3]),
        .k4    (kin[4]),
        .k5    (kin[5]),
        .k6    (kin[6]),
        .k7    (kin[7]),
        .k8    (kin[8]),
        .out   (out),
        .done  (done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] model_sum();
        int s;
        s = 0;
        for (int i = 0; i < 9; i++) s += int'(win[i]) * int'(kin[i]);
        return s[15:0];
    endfunction

    // scoreboard
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                check("sb_out", {16'd0, out}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic set_all(input int w, input int k);
        for (int i = 0; i < 9; i++) begin
            win[i] = w[7:0];
            kin[i] = k[7:0];
        end
    endtask

    task automatic fire();
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(model_sum());
        @(posedge clk);
        #1;
        check("done_latency", {31'd0, done}, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] held;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        start = 1'b0;
        set_all(0, 0);

        // reset then idle
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_out", {16'd0, out}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("idle_out", {16'd0, out}, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
        end

        // all ones, single pulse, then hold with changing inputs
        set_all(1, 1);
        fire();
        check("ones_out", {16'd0, out}, 32'd9);
        set_all(7, 3);
        @(posedge clk);
        #1;
        check("ones_done_low", {31'd0, done}, 32'd0);
        check("ones_hold", {16'd0, out}, 32'd9);

        // positional weighting
        for (int i = 0; i < 9; i++) begin
            win[i] = 8'(i + 1);
            kin[i] = 8'(i + 1);
        end
        fire();
        check("pos_285", {16'd0, out}, 32'd285);
        for (int i = 0; i < 9; i++) kin[i] = 8'd0;
        kin[4] = 8'd2;
        fire();
        check("pos_center", {16'd0, out}, 32'd10);

        // overflow wrap
        set_all(255, 255);
        fire();
        check("wrap_out", {16'd0, out}, 32'd60937);
        @(posedge clk);
        #1;
        check("wrap_done_low", {31'd0, done}, 32'd0);

        // back-to-back start for three cycles
        set_all(0, 0);
        kin[0] = 8'd5;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            win[0] = 8'(n);
            start  = 1'b1;
            exp_q.push_back(model_sum());
            @(posedge clk);
            #1;
            check("b2b_done", {31'd0, done}, 32'd1);
            check("b2b_out", {16'd0, out}, 32'(5 * n));
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_done_low", {31'd0, done}, 32'd0);
        check("b2b_hold", {16'd0, out}, 32'd15);

        // random vectors, some back-to-back
        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            for (int i = 0; i < 9; i++) begin
                win[i] = 8'($urandom_range(0, 255));
                kin[i] = 8'($urandom_range(0, 255));
            end
            start = ($urandom_range(0, 2) != 0);
            if (start) exp_q.push_back(model_sum());
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);

        // asynchronous reset while a result is valid
        set_all(1, 1);
        fire();
        check("pre_rst_done", {31'd0, done}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_out", {16'd0, out}, 32'd0);
        check("async_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        check("async_held", {16'd0, out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", {31'd0, done}, 32'd0);
        held = out;
        check("post_rst_out", {16'd0, held}, 32'd0);
        fire();
        check("post_rst_ones", {16'd0, out}, 32'd9);

        repeat (2) @(negedge clk);
        check("sb_drain", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv2d_unroll9.md
Name: conv2d_unroll9

Overview:
Fully parallel 3x3 convolution engine. It multiplies a 9-element pixel window by a 9-element kernel using 9 concurrent multipliers and an adder tree. One result is produced per start pulse, one clock after start is sampled. It is the single-cycle variant in the conv-accelerator family and is fed by the window/kernel registers of the surrounding datapath.

Parameters:
DATA_W, 8, width of each pixel and kernel coefficient (unsigned)
OUT_W, 16, width of result register; sum wraps modulo 2^OUT_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (0 = reset asserted)
start  input  1  compute request; sampled on rising clk edge
in0..in8  input  DATA_W each  3x3 window, row-major (in0 top-left, in8 bottom-right)
k0..k8  input  DATA_W each  3x3 kernel, row-major, same indexing as in0..in8
out  output  OUT_W  registered convolution result
done  output  1  registered one-cycle result-valid pulse

Behaviour:
- Reset (rst=0, asynchronous): out=0, done=0 immediately, independent of clk. Held while rst=0.
- Datapath:
  - Combinational products p_i = in_i * k_i, unsigned, each 2*DATA_W bits.
  - Adder tree sums the 9 products at full width: 2*DATA_W+4 bits internally.
  - out takes the low OUT_W bits of the sum (wrap, no saturation).
- Capture: on a rising edge with rst=1 and start=1:
  - out <= sum of products of the inputs present at that edge.
  - done <= 1.
- Latency: 1 cycle. done and out are valid together after the same edge that sampled start.
- On a rising edge with start=0: done <= 0 and out holds its last value. No recomputation, and input changes are ignored.
- Back-to-back start (held high N cycles): a new result is registered every cycle and done stays high for N cycles. Each result reflects the inputs at its own sampling edge.
- No busy state and no FSM beyond the done register. start is always accepted.
- Reset mid-operation: asynchronous clear wins. Any pending result is discarded, and out=0, done=0 until the next start after reset release.
- start asserted in the same edge as reset release: the edge is ignored if rst is still 0 at that edge; otherwise it is processed normally.
- Worst case: all 255 gives 9*65025 = 585225. out = 585225 mod 65536 = 60937.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, start=0 -> out=0, done=0 throughout and after release while start stays 0.
- All-ones: in0..in8=1, k0..k8=1, single-cycle start pulse -> done=1 on the edge that samples start (0 extra cycles), out=9. done=0 on the next edge and out stays 9.
- Positional weighting: in_i=i+1 (1..9), k_i=i+1 -> out=285. Then k4=2, all other k=0 -> out=10.
- Overflow wrap: all in and k = 255 -> out=60937, done pulses once.
- Back-to-back start for 3 cycles with in0 changing 1,2,3 (others 0, k0=5) -> out 5,10,15 on consecutive edges, done high for 3 cycles then 0.
- Async reset mid-result: after out=9 and done=1, drop rst between clock edges -> out=0 and done=0 immediately. After release and a new start with all-ones inputs, out=9.
